// File: rtl/riscv_fetch_buffer_pkg.sv
// -----------------------------------------------------------------------------
// riscv_fetch_buffer_pkg
// Shared definitions for the instruction fetch buffer: the reset vector, the
// fetch request/response and decode-input record types, the fetch credit
// count, and the PC increment helper.
// No ports (package).
// -----------------------------------------------------------------------------
package riscv_fetch_buffer_pkg;

   // Address of the first instruction fetched after reset.
   localparam logic [31:0] RISCV_RESET_VECTOR = 32'h0000_0000;

   // Requests in flight plus buffered instructions may never exceed this;
   // it equals the FIFO depth so every response is guaranteed a slot.
   localparam int unsigned FETCH_CREDITS = 2;

   // Request presented to instruction memory.
   typedef struct packed {
      logic        valid;
      logic [31:0] address;
   } ifetch_req_t;

   // In-order response returned by instruction memory.
   typedef struct packed {
      logic        valid;
      logic [31:0] data;
   } ifetch_resp_t;

   // One buffered instruction as seen by the decoder.
   typedef struct packed {
      logic [31:0] instruction;
      logic [31:0] pc;
   } dec_in_t;

   // Sequential PC; wraps modulo 2^32.
   function automatic logic [31:0] pc_next(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage : riscv_fetch_buffer_pkg

// File: rtl/riscv_fetch_buffer_if.sv
// -----------------------------------------------------------------------------
// riscv_fetch_buffer_if
// Bundles the fetch buffer's memory, redirect and decode signals.
//   ifetch_req_valid/ready/address : fetch request handshake
//   ifetch_resp_valid/data         : in-order response from memory
//   flush/flush_pc                 : redirect from execute
//   dec_valid/ready/instruction/pc : instruction handshake to the decoder
// Modports:
//   master : the fetch buffer itself
//   slave  : the environment (memory, execute and decoder side)
// -----------------------------------------------------------------------------
interface riscv_fetch_buffer_if;

   logic        ifetch_req_valid;
   logic        ifetch_req_ready;
   logic [31:0] ifetch_req_address;
   logic        ifetch_resp_valid;
   logic [31:0] ifetch_resp_data;
   logic        flush;
   logic [31:0] flush_pc;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_instruction;
   logic [31:0] dec_pc;

   modport master (
      output ifetch_req_valid,
      input  ifetch_req_ready,
      output ifetch_req_address,
      input  ifetch_resp_valid,
      input  ifetch_resp_data,
      input  flush,
      input  flush_pc,
      output dec_valid,
      input  dec_ready,
      output dec_instruction,
      output dec_pc
   );

   modport slave (
      input  ifetch_req_valid,
      output ifetch_req_ready,
      input  ifetch_req_address,
      output ifetch_resp_valid,
      output ifetch_resp_data,
      output flush,
      output flush_pc,
      input  dec_valid,
      output dec_ready,
      input  dec_instruction,
      input  dec_pc
   );

endinterface : riscv_fetch_buffer_if

// File: rtl/riscv_fetch_fifo2.sv
// -----------------------------------------------------------------------------
// riscv_fetch_fifo2
// Two-entry FIFO of {instruction, pc}. Entry 0 is always the head. Supports
// push and pop in the same cycle at any occupancy (no bubble); flush empties
// it and wins over push/pop. The head reads as zero while empty.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   flush_i      : discard all entries
//   push_i       : write push_data_i (ignored when full and not popping)
//   push_data_i  : entry to write
//   pop_i        : remove the head (ignored when empty)
//   head_o       : current head entry, zero when empty
//   empty_o      : no entries
//   full_o       : two entries
//   count_o      : occupancy 0..2
// -----------------------------------------------------------------------------
module riscv_fetch_fifo2
   import riscv_fetch_buffer_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       flush_i,
   input  logic       push_i,
   input  dec_in_t    push_data_i,
   input  logic       pop_i,
   output dec_in_t    head_o,
   output logic       empty_o,
   output logic       full_o,
   output logic [1:0] count_o
);

   dec_in_t    entry_q [2];
   dec_in_t    entry_d [2];
   logic [1:0] count_q, count_d;
   logic       push_eff, pop_eff;

   assign pop_eff  = pop_i && (count_q != 2'd0);
   assign push_eff = push_i && ((count_q != 2'd2) || pop_eff);

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
      entry_d = entry_q;
      count_d = count_q;
      if (flush_i) begin
         count_d = 2'd0;
      end else begin
         case ({push_eff, pop_eff})
            2'b10: begin
               // count is 0 or 1 here: write the first free slot.
               entry_d[count_q[0]] = push_data_i;
               count_d             = count_q + 2'd1;
            end
            2'b01: begin
               entry_d[0] = entry_q[1];
               count_d    = count_q - 2'd1;
            end
            2'b11: begin
               // Occupancy unchanged; the new entry lands behind the survivor.
               if (count_q == 2'd2) begin
                  entry_d[0] = entry_q[1];
                  entry_d[1] = push_data_i;
               end else begin
                  entry_d[0] = push_data_i;
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= 2'd0;
      end else begin
         count_q <= count_d;
      end
   end

   // NOTE: the data storage is deliberately not reset; count_q alone decides which entries are valid.
   always_ff @(posedge clk) begin
      entry_q <= entry_d;
   end

   assign empty_o = (count_q == 2'd0);
   assign full_o  = (count_q == 2'd2);
   assign count_o = count_q;
   assign head_o  = empty_o ? '0 : entry_q[0];

endmodule : riscv_fetch_fifo2

// File: rtl/riscv_fetch_buffer.sv
// -----------------------------------------------------------------------------
// riscv_fetch_buffer
// Instruction fetch front end: issues word-aligned fetch requests, tracks
// responses in order, buffers up to two instructions for the decoder and
// handles redirects by discarding responses to requests already in flight.
// A request is only issued while (outstanding + occupancy) < 2, so every
// response is guaranteed a FIFO slot.
// Ports:
//   clk    : sole clock, rising edge
//   reset  : synchronous active-high reset
//   bus    : riscv_fetch_buffer_if.master (memory request/response, flush,
//            decoder handshake)
// Configuration:
//   RISCV_FETCH_BUFFER_BYPASS_EN : when defined, a non-dropped response to an
//   empty FIFO is presented to the decoder combinationally in the same cycle
//   and is not stored if the decoder takes it. Undefined (default): responses
//   are always registered, one cycle of fetch-to-decode latency.
// -----------------------------------------------------------------------------
module riscv_fetch_buffer
   import riscv_fetch_buffer_pkg::*;
(
   input logic                  clk,
   input logic                  reset,
   riscv_fetch_buffer_if.master bus
);

   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] resp_pc_q, resp_pc_d;
   logic [1:0]  outstanding_q, outstanding_d;
   logic [1:0]  drop_count_q, drop_count_d;

   ifetch_req_t  req;
   ifetch_resp_t resp;
   dec_in_t      push_entry;
   dec_in_t      fifo_head;
   dec_in_t      dec_out;
   logic         fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [1:0]   occupancy;
   logic [2:0]   credits_used;
   logic         req_fire, resp_keep, resp_drop, dec_valid;

   assign resp.valid = bus.ifetch_resp_valid;
   assign resp.data  = bus.ifetch_resp_data;

   assign credits_used = {1'b0, outstanding_q} + {1'b0, occupancy};

   // Reset gates the request so nothing is issued before state has cleared.
   assign req.valid   = !reset && !bus.flush && (credits_used < 3'(FETCH_CREDITS));
   assign req.address = {fetch_pc_q[31:2], 2'b00};
   assign req_fire    = req.valid && bus.ifetch_req_ready;

   // Responses owed to requests issued before a flush are discarded.
   assign resp_keep  = resp.valid && (drop_count_q == 2'd0);
   assign resp_drop  = resp.valid && (drop_count_q != 2'd0);
   assign push_entry = '{instruction: resp.data, pc: resp_pc_q};

`ifdef RISCV_FETCH_BUFFER_BYPASS_EN
   logic bypass_hit;

   // A kept response to an empty FIFO goes straight to the decoder; it is
   // only stored if the decoder cannot take it this cycle.
   assign bypass_hit = resp_keep && fifo_empty && !bus.flush;
   assign dec_valid  = !reset && (!fifo_empty || bypass_hit);
   assign dec_out    = !fifo_empty ? fifo_head : (bypass_hit ? push_entry : '0);
   assign fifo_push  = resp_keep && !bus.flush && !(bypass_hit && bus.dec_ready);
`else
   assign dec_valid = !reset && !fifo_empty;
   assign dec_out   = fifo_head;
   assign fifo_push = resp_keep && !bus.flush;
`endif

   assign fifo_pop = !fifo_empty && bus.dec_ready && !bus.flush;

   riscv_fetch_fifo2 u_fifo (
      .clk         (clk),
      .reset       (reset),
      .flush_i     (bus.flush),
      .push_i      (fifo_push),
      .push_data_i (push_entry),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .empty_o     (fifo_empty),
      .full_o      (fifo_full),
      .count_o     (occupancy)
   );

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      drop_count_d  = drop_count_q;
      // req_fire is already low during a flush, so this holds either way.
      outstanding_d = outstanding_q + {1'b0, req_fire} - {1'b0, resp.valid};
      if (bus.flush) begin
         fetch_pc_d = bus.flush_pc;
         resp_pc_d  = bus.flush_pc;
         // Everything still in flight after this edge is stale.
         drop_count_d = outstanding_q - {1'b0, resp.valid};
      end else begin
         if (req_fire)  fetch_pc_d   = pc_next(fetch_pc_q);
         if (resp_keep) resp_pc_d    = pc_next(resp_pc_q);
         if (resp_drop) drop_count_d = drop_count_q - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q    <= RISCV_RESET_VECTOR;
         resp_pc_q     <= RISCV_RESET_VECTOR;
         outstanding_q <= 2'd0;
         drop_count_q  <= 2'd0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_count_q  <= drop_count_d;
      end
   end

   assign bus.ifetch_req_valid   = req.valid;
   assign bus.ifetch_req_address = req.address;
   assign bus.dec_valid          = dec_valid;
   assign bus.dec_instruction    = dec_out.instruction;
   assign bus.dec_pc             = dec_out.pc;

endmodule : riscv_fetch_buffer

// File: tb/tb_riscv_fetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_riscv_fetch_buffer
// Drives riscv_fetch_buffer with an in-order memory model of programmable
// latency. Every accepted request pushes {address, word} onto an expected
// queue; every instruction the decoder takes is popped and compared. A flush
// or reset empties the expected queue, since nothing fetched before it may
// reach the decoder afterwards.
// -----------------------------------------------------------------------------
module tb_riscv_fetch_buffer;
   import riscv_fetch_buffer_pkg::*;

`ifdef RISCV_FETCH_BUFFER_BYPASS_EN
   localparam int DEC_LAT = 0;
`else
   localparam int DEC_LAT = 1;
`endif

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   riscv_fetch_buffer_if bus ();

   riscv_fetch_buffer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   exp_t        exp_q[$];
   logic [31:0] pend_addr[$];
   int          pend_due[$];
   logic [31:0] acc_log[$];
   int          pop_cyc[$];
   int          cyc      = 0;
   int          last_due = 0;
   int          mem_lat  = 1;
   int          errors   = 0;
   int          checks   = 0;
   int          first_resp_cyc = -1;
   int          first_dec_cyc  = -1;
   logic [31:0] flush_pc_chk;
   bit          flush_chk_armed = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a << 8) | 32'h0000_0013;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Mid-cycle: observe what the DUT will do at the coming edge.
   task automatic sample();
      exp_t e;
      int   due;
      if (reset) return;
      if (bus.flush) begin
         check("req_during_flush", {31'b0, bus.ifetch_req_valid}, 32'd0);
         exp_q.delete();
         acc_log.delete();
      end
      if (first_resp_cyc < 0 && bus.ifetch_resp_valid) first_resp_cyc = cyc;
      if (first_dec_cyc < 0 && bus.dec_valid) first_dec_cyc = cyc;
      if (bus.ifetch_resp_valid && !bus.flush && dut.drop_count_q == 2'd0)
         check("fifo_overflow", {31'b0, dut.fifo_full && !dut.fifo_pop}, 32'd0);
      if (bus.ifetch_req_valid && bus.ifetch_req_ready && !bus.flush) begin
         due = cyc + mem_lat;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         pend_addr.push_back(bus.ifetch_req_address);
         pend_due.push_back(due);
         acc_log.push_back(bus.ifetch_req_address);
         e.pc    = bus.ifetch_req_address;
         e.instr = mem_word(bus.ifetch_req_address);
         exp_q.push_back(e);
      end
      if (bus.dec_valid && bus.dec_ready && !bus.flush) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pop", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("dec_pc", bus.dec_pc, e.pc);
            check("dec_instr", bus.dec_instruction, e.instr);
         end
         pop_cyc.push_back(cyc);
         if (flush_chk_armed) begin
            check("flush_first_pc", bus.dec_pc, flush_pc_chk);
            flush_chk_armed = 0;
         end
      end
   endtask

   // Just after the edge: present this cycle's memory response.
   task automatic drive_mem();
      cyc++;
      bus.flush = 1'b0;
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
         bus.ifetch_resp_valid = 1'b1;
         bus.ifetch_resp_data  = mem_word(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end else begin
         bus.ifetch_resp_valid = 1'b0;
         bus.ifetch_resp_data  = 32'hDEAD_BEEF;
      end
   endtask

   task automatic step();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
      drive_mem();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      exp_q.delete();
      pend_addr.delete();
      pend_due.delete();
      for (int i = 0; i < n; i++) begin
         step();
         if (i == 1) begin
            #1;
            check("rst_req_valid", {31'b0, bus.ifetch_req_valid}, 32'd0);
            check("rst_dec_valid", {31'b0, bus.dec_valid}, 32'd0);
            check("rst_dec_pc", bus.dec_pc, 32'd0);
            check("rst_dec_instr", bus.dec_instruction, 32'd0);
         end
      end
      reset = 1'b0;
      acc_log.delete();
      pop_cyc.delete();
      first_resp_cyc = -1;
      first_dec_cyc  = -1;
   endtask

   initial begin
      int          max_sz;
      logic [31:0] r;

      reset                 = 1'b1;
      bus.ifetch_req_ready  = 1'b1;
      bus.ifetch_resp_valid = 1'b0;
      bus.ifetch_resp_data  = 32'd0;
      bus.flush             = 1'b0;
      bus.flush_pc          = 32'd0;
      bus.dec_ready         = 1'b1;
      @(posedge clk);
      #1;
      drive_mem();
      do_reset(3);

      // Streaming from reset: addresses 0,4,8; decoder sees pc 0 then 4 back to back.
      run(8);
      if (acc_log.size() < 3) begin
         check("boot_req_count", acc_log.size(), 32'd3);
      end else begin
         check("boot_addr0", acc_log[0], 32'h0);
         check("boot_addr1", acc_log[1], 32'h4);
         check("boot_addr2", acc_log[2], 32'h8);
      end
      if (pop_cyc.size() < 2) check("boot_pop_count", pop_cyc.size(), 32'd2);
      else check("boot_pop_gap", pop_cyc[1] - pop_cyc[0], 32'd1);
      check("resp_to_dec_latency", first_dec_cyc - first_resp_cyc, DEC_LAT);

      // Decoder stalls five cycles: credits cap fetched-but-unconsumed at two.
      bus.dec_ready = 1'b0;
      max_sz = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (exp_q.size() > max_sz) max_sz = exp_q.size();
      end
      #1;
      check("stall_req_valid", {31'b0, bus.ifetch_req_valid}, 32'd0);
      check("stall_buffered", exp_q.size(), 32'd2);
      check("stall_credit_cap", {31'b0, max_sz > 2}, 32'd0);
      bus.dec_ready = 1'b1;
      run(6);

      // Drain, then flush to 0x100 with two requests in flight.
      bus.ifetch_req_ready = 1'b0;
      run(5);
      check("drain_empty", exp_q.size(), 32'd0);
      bus.ifetch_req_ready = 1'b1;
      mem_lat = 3;
      for (int i = 0; i < 20 && !(pend_addr.size() == 2 && !bus.ifetch_resp_valid); i++) step();
      check("wait_two_outstanding", {31'b0, pend_addr.size() == 2 && !bus.ifetch_resp_valid}, 32'd1);
      bus.flush       = 1'b1;
      bus.flush_pc    = 32'h100;
      flush_pc_chk    = 32'h100;
      flush_chk_armed = 1;
      step();
      #1;
      check("flush2_drop_count", {30'b0, dut.drop_count_q}, 32'd2);
      run(15);
      check("flush2_target_seen", {31'b0, flush_chk_armed}, 32'd0);

      // Flush in the same cycle as a kept response with one more in flight.
      mem_lat = 2;
      for (int i = 0; i < 20 && !(bus.ifetch_resp_valid && pend_addr.size() == 1); i++) step();
      check("wait_resp_plus_one", {31'b0, bus.ifetch_resp_valid && pend_addr.size() == 1}, 32'd1);
      bus.flush       = 1'b1;
      bus.flush_pc    = 32'h200;
      flush_pc_chk    = 32'h200;
      flush_chk_armed = 1;
      step();
      #1;
      check("flush1_fifo_empty", {31'b0, bus.dec_valid}, 32'd0);
      check("flush1_drop_count", {30'b0, dut.drop_count_q}, 32'd1);
      run(12);
      check("flush1_target_seen", {31'b0, flush_chk_armed}, 32'd0);

      // PC wrap at the top of the address space.
      mem_lat      = 1;
      bus.flush    = 1'b1;
      bus.flush_pc = 32'hFFFF_FFF8;
      step();
      run(8);
      if (acc_log.size() < 3) begin
         check("wrap_req_count", acc_log.size(), 32'd3);
      end else begin
         check("wrap_addr0", acc_log[0], 32'hFFFF_FFF8);
         check("wrap_addr1", acc_log[1], 32'hFFFF_FFFC);
         check("wrap_addr2", acc_log[2], 32'h0000_0000);
      end

      // Random back-pressure, latency and redirects.
      for (int i = 0; i < 400; i++) begin
         step();
         bus.ifetch_req_ready = ($urandom_range(3) != 0);
         bus.dec_ready        = ($urandom_range(2) != 0);
         mem_lat              = $urandom_range(3, 1);
         if ($urandom_range(39) == 0) begin
            r            = $urandom;
            bus.flush    = 1'b1;
            bus.flush_pc = {r[31:2], 2'b00};
         end
      end

      // Reset mid-traffic restarts fetching at the reset vector.
      bus.ifetch_req_ready = 1'b1;
      bus.dec_ready        = 1'b1;
      do_reset(2);
      run(4);
      if (acc_log.size() < 1) check("rerst_req_count", acc_log.size(), 32'd1);
      else check("rerst_addr0", acc_log[0], RISCV_RESET_VECTOR);

      bus.ifetch_req_ready = 1'b0;
      run(8);
      check("final_drain", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_riscv_fetch_buffer
